axi_core_arbiter: RTL and testbench
===================================

Name: axi_core_arbiter

Overview:
- N-master to 1-slave AXI4 interconnect stage that lets several CROSP core tops share one memory-side AXI port.
- Sits between the cores' m_axi_* buses and the SoC memory/peripheral fabric.
- Generalises the single-port core boundary to `nm` channels.
- Adds round-robin arbitration, ID tagging by master index, W-channel ordering and B/R response routing.

Parameters:
nm, 2, number of upstream masters (≥2)
idw, 8, AXI ID width on both sides
wqsz, 4, depth of the AW-grant order FIFO that steers W beats (power of 2)
ixw, $clog2(nm), master-index width, derived; top ixw ID bits carry the index

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
s_ar  in  nm×ar_t  per-master read address; includes valid bit
s_arready  out  nm  per-master AR ready
s_aw  in  nm×aw_t  per-master write address; includes valid bit
s_awready  out  nm  per-master AW ready
s_w  in  nm×w_t  per-master write data; includes valid and last
s_wready  out  nm  per-master W ready
s_b  out  nm×b_t  per-master write response; includes valid bit
s_bready  in  nm  per-master B ready
s_r  out  nm×r_t  per-master read data; includes valid and last
s_rready  in  nm  per-master R ready
m_ar  out  ar_t  downstream AR, registered
m_arready  in  1  downstream AR ready
m_aw  out  aw_t  downstream AW, registered
m_awready  in  1  downstream AW ready
m_w  out  w_t  downstream W
m_wready  in  1  downstream W ready
m_b  in  b_t  downstream B
m_bready  out  1  downstream B ready
m_r  in  r_t  downstream R
m_rready  out  1  downstream R ready

Behaviour:
- Reset (rst==0 at a clk edge):
  - m_ar.valid, m_aw.valid = 0.
  - W FIFO empty.
  - AR and AW round-robin pointers = 0.
  - All s_*ready = 0; m_bready, m_rready = 0.
  - All s_b.valid, s_r.valid = 0.
  - Reset mid-burst drops all in-flight state; no completion is owed.
- AR channel: one-entry output register.
  - Load condition: register empty, or m_ar.valid && m_arready in the same cycle.
  - Winner: first valid master at or after rr_ar; rr_ar then becomes winner+1 mod nm.
  - s_arready[i] = 1 only for the winner in the load cycle.
  - Latency is 1 cycle from the upstream handshake to m_ar.valid.
  - Back-to-back throughput is 1/cycle.
  - m_ar.id = {winner[ixw-1:0], s_ar.id[idw-ixw-1:0]}; upstream ID bits above idw-ixw are discarded.
  - All other fields pass unchanged.
- AW channel: identical to AR, plus:
  - Loading pushes the winner index into the W FIFO.
  - AW is not granted while the FIFO is full; it resumes the cycle after a pop frees a slot.
- W channel:
  - When the FIFO is non-empty, head = sel.
  - m_w = s_w[sel]; s_wready[sel] = m_wready; all other s_wready = 0.
  - A handshake with last=1 pops the head.
  - FIFO empty: m_w.valid = 0, which blocks W until its AW is registered.
  - W may not lead AW.
  - Push and pop in the same cycle leave the count unchanged, including when full.
  - Pointers wrap mod wqsz.
- B channel:
  - sel = m_b.id[idw-1:idw-ixw].
  - s_b[sel] = m_b with the index bits cleared; all other s_b.valid = 0.
  - m_bready = s_bready[sel], combinational.
- R channel: same routing as B; bursts pass beat-by-beat with last preserved.
- Out-of-range index (≥nm, non-power-of-2 nm): the response is sunk with m_*ready = 1 and dropped.
- Simultaneous AR and AW from the same master are independent and may both be granted in one cycle.
- Once a master's valid is high, arbitration never changes the presented payload; AXI no-withdraw holds upstream.

Optional Feature:
AXI_ARB_QOS_EN:
- Defined: on AR and AW, the highest .qos among valid masters wins; ties go round-robin from the pointer.
- Undefined: .qos is ignored for arbitration (pure round-robin) but is still forwarded downstream.

Decomposition:
- Package axi_pkg:
  - ar_t and aw_t: valid, id, addr[63:0], len[7:0], size[2:0], burst[1:0], lock, cache[3:0], prot[2:0], qos[3:0].
  - w_t: valid, data[63:0], strb[7:0], last.
  - b_t: valid, id, resp[1:0].
  - r_t: valid, id, data[63:0], resp[1:0], last.
  - Constants AXI_BURST_INCR and AXI_RESP_OKAY.
- Sub-module rr_arbiter:
  - Parameters n and qos_en.
  - Inputs: request vector, optional qos vector, advance strobe.
  - Outputs: one-hot grant and index; owns the pointer.
  - Instantiated once for AR and once for AW.

Test Plan:
- Round-robin fairness: nm=2; both masters hold AR valid (addr 0x1000, 0x2000), m_arready=1 → m_ar.addr alternates 0x1000, 0x2000, 0x1000… with ids 0x00/0x80, one per cycle after 1 cycle of latency.
- W ordering: M1 AW (len=3), then M0 AW (len=0), both granted → the 4 W beats from M1 are forwarded before M0's single beat; M0 wready stays 0 until M1's last beat.
- FIFO full: wqsz=4; 4 AWs granted, no W sent → 5th AW gets s_awready=0; one W last beat → that AW is granted the next cycle.
- Response routing: inject m_r id=0x85, 4 beats, s_rready[1] toggling → only s_r[1] is valid, id=0x05, m_rready follows s_rready[1], last on beat 4.
- Mid-transfer reset: rst low for 1 cycle during an AR grant and a W burst → all valids and readys are 0 on the next cycle, the FIFO is empty, and the pointer restarts at master 0.
- QoS (AXI_ARB_QOS_EN): M0 qos=2 and M1 qos=9 both valid → M1 wins; with equal qos, alternation resumes.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI4 channel payload types and shared constants for the multi-master core arbiter.
package axi_pkg;

  localparam int AXI_IDW = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic               valid;
    logic [AXI_IDW-1:0] id;
    logic [63:0]        addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic               lock;
    logic [3:0]         cache;
    logic [2:0]         prot;
    logic [3:0]         qos;
  } ar_t;

  typedef struct packed {
    logic               valid;
    logic [AXI_IDW-1:0] id;
    logic [63:0]        addr;
    logic [7:0]         len;
    logic [2:0]         size;
    logic [1:0]         burst;
    logic               lock;
    logic [3:0]         cache;
    logic [2:0]         prot;
    logic [3:0]         qos;
  } aw_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_t;

  typedef struct packed {
    logic               valid;
    logic [AXI_IDW-1:0] id;
    logic [1:0]         resp;
  } b_t;

  typedef struct packed {
    logic               valid;
    logic [AXI_IDW-1:0] id;
    logic [63:0]        data;
    logic [1:0]         resp;
    logic               last;
  } r_t;

  // Clears the top ixw bits that carry the master index
  function automatic logic [AXI_IDW-1:0] strip_index(input logic [AXI_IDW-1:0] id, input int ixw);
    logic [AXI_IDW-1:0] res;
    res = id;
    for (int k = 0; k < AXI_IDW; k++) begin
      if (k >= AXI_IDW - ixw) res[k] = 1'b0;
      else                    res[k] = id[k];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_core_arbiter_rr_arbiter.sv
// Round-robin arbiter with optional QoS priority; owns the rotating pointer.
// With qos_en set the highest qos wins and ties fall back to round-robin order.
module rr_arbiter #(
  parameter int n      = 2,
  parameter bit qos_en = 1'b0,
  parameter int iw     = (n > 1) ? $clog2(n) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [n-1:0]   req,
  input  logic [4*n-1:0] qos,
  input  logic           adv,
  output logic [n-1:0]   gnt,
  output logic [iw-1:0]  idx,
  output logic           any
);

  logic [iw-1:0] ptr_r;
  logic [iw-1:0] win_s;
  logic [3:0]    best_q_s;
  logic [3:0]    cand_q_s;
  logic          found_s;
  int            cand_s;

  // Scan from the pointer; a strictly higher qos is needed to displace an earlier candidate
  always_comb begin
    win_s    = ptr_r;
    best_q_s = 4'd0;
    cand_q_s = 4'd0;
    found_s  = 1'b0;
    cand_s   = 0;
    for (int k = 0; k < n; k++) begin
      cand_s   = (int'(ptr_r) + k) % n;
      cand_q_s = qos_en ? qos[4*cand_s +: 4] : 4'd0;
      if (req[cand_s] && (!found_s || (cand_q_s > best_q_s))) begin
        found_s  = 1'b1;
        best_q_s = cand_q_s;
        win_s    = iw'(cand_s);
      end else begin
        found_s  = found_s;
      end
    end
    gnt = {n{1'b0}};
    if (found_s) gnt[win_s] = 1'b1;
    else         gnt = {n{1'b0}};
    idx = win_s;
    any = found_s;
  end

  // Pointer moves to the slot after the winner on every grant
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r <= {iw{1'b0}};
    end else if (adv && found_s) begin
      ptr_r <= (int'(win_s) == n - 1) ? {iw{1'b0}} : win_s + iw'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/axi_core_arbiter.sv
// N-master to 1-slave AXI4 stage: round-robin AR/AW, master index in the top ID bits,
// W steered by AW grant order, B/R routed back by ID. Define AXI_ARB_QOS_EN for qos priority.
module axi_core_arbiter
  import axi_pkg::*;
#(
  parameter int nm   = 2,
  parameter int idw  = AXI_IDW,
  parameter int wqsz = 4,
  parameter int ixw  = $clog2(nm)
) (
  input  logic          clk,
  input  logic          rst,
  input  ar_t           s_ar [nm],
  output logic [nm-1:0] s_arready,
  input  aw_t           s_aw [nm],
  output logic [nm-1:0] s_awready,
  input  w_t            s_w [nm],
  output logic [nm-1:0] s_wready,
  output b_t            s_b [nm],
  input  logic [nm-1:0] s_bready,
  output r_t            s_r [nm],
  input  logic [nm-1:0] s_rready,
  output ar_t           m_ar,
  input  logic          m_arready,
  output aw_t           m_aw,
  input  logic          m_awready,
  output w_t            m_w,
  input  logic          m_wready,
  input  b_t            m_b,
  output logic          m_bready,
  input  r_t            m_r,
  output logic          m_rready
);

`ifdef AXI_ARB_QOS_EN
  localparam bit QOS_EN = 1'b1;
`else
  localparam bit QOS_EN = 1'b0;
`endif

  localparam int QW = $clog2(wqsz);
  localparam int CW = QW + 1;
  localparam logic [ixw:0] NM_LIM = (ixw + 1)'(nm);

  logic [nm-1:0]   ar_req_s, aw_req_s, ar_gnt_s, aw_gnt_s;
  logic [4*nm-1:0] ar_qos_s, aw_qos_s;
  logic [ixw-1:0]  ar_idx_s, aw_idx_s;
  logic            ar_any_s, aw_any_s;
  logic            ar_load_s, ar_take_s, aw_load_s, aw_take_s;
  ar_t             ar_reg_r, ar_next_s;
  aw_t             aw_reg_r, aw_next_s;

  logic [ixw-1:0]  fifo_mem_r [wqsz];
  logic [QW-1:0]   fifo_wp_r, fifo_rp_r;
  logic [CW-1:0]   fifo_cnt_r;
  logic            fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic [ixw-1:0]  w_sel_s;
  w_t              w_cur_s;

  logic [ixw-1:0]  b_sel_s, r_sel_s;
  logic            b_in_range_s, r_in_range_s;

  // Gather request and qos vectors for both arbiters
  always_comb begin
    ar_req_s = {nm{1'b0}};
    aw_req_s = {nm{1'b0}};
    ar_qos_s = {(4*nm){1'b0}};
    aw_qos_s = {(4*nm){1'b0}};
    for (int i = 0; i < nm; i++) begin
      ar_req_s[i]       = s_ar[i].valid;
      aw_req_s[i]       = s_aw[i].valid;
      ar_qos_s[4*i +: 4] = s_ar[i].qos;
      aw_qos_s[4*i +: 4] = s_aw[i].qos;
    end
  end

  rr_arbiter #(.n(nm), .qos_en(QOS_EN), .iw(ixw)) u_ar_arb (
    .clk(clk), .rst(rst), .req(ar_req_s), .qos(ar_qos_s), .adv(ar_take_s),
    .gnt(ar_gnt_s), .idx(ar_idx_s), .any(ar_any_s)
  );

  rr_arbiter #(.n(nm), .qos_en(QOS_EN), .iw(ixw)) u_aw_arb (
    .clk(clk), .rst(rst), .req(aw_req_s), .qos(aw_qos_s), .adv(aw_take_s),
    .gnt(aw_gnt_s), .idx(aw_idx_s), .any(aw_any_s)
  );

  // Address channel load/grant decisions and ID tagging
  always_comb begin
    ar_load_s    = !ar_reg_r.valid || m_arready;
    ar_take_s    = rst && ar_load_s && ar_any_s;
    ar_next_s    = s_ar[ar_idx_s];
    ar_next_s.id = {ar_idx_s, s_ar[ar_idx_s].id[idw-ixw-1:0]};
    s_arready    = ar_take_s ? ar_gnt_s : {nm{1'b0}};

    aw_load_s    = !aw_reg_r.valid || m_awready;
    aw_take_s    = rst && aw_load_s && aw_any_s && !fifo_full_s;
    aw_next_s    = s_aw[aw_idx_s];
    aw_next_s.id = {aw_idx_s, s_aw[aw_idx_s].id[idw-ixw-1:0]};
    s_awready    = aw_take_s ? aw_gnt_s : {nm{1'b0}};
  end

  // AR output register
  always_ff @(posedge clk) begin
    if (!rst) begin
      ar_reg_r <= '0;
    end else if (ar_load_s) begin
      if (ar_any_s) ar_reg_r <= ar_next_s;
      else          ar_reg_r <= '0;
    end else begin
      ar_reg_r <= ar_reg_r;
    end
  end

  // AW output register; a full W-order FIFO empties it instead of loading
  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_reg_r <= '0;
    end else if (aw_take_s) begin
      aw_reg_r <= aw_next_s;
    end else if (aw_load_s) begin
      aw_reg_r <= '0;
    end else begin
      aw_reg_r <= aw_reg_r;
    end
  end

  assign m_ar = ar_reg_r;
  assign m_aw = aw_reg_r;

  // W routing follows the oldest granted AW; an empty FIFO blocks W entirely
  always_comb begin
    fifo_full_s  = (fifo_cnt_r == CW'(wqsz));
    fifo_empty_s = (fifo_cnt_r == {CW{1'b0}});
    w_sel_s      = fifo_mem_r[fifo_rp_r];
    w_cur_s      = s_w[w_sel_s];
    m_w          = w_cur_s;
    s_wready     = {nm{1'b0}};
    if (rst && !fifo_empty_s) begin
      s_wready[w_sel_s] = m_wready;
    end else begin
      m_w.valid = 1'b0;
    end
    fifo_pop_s   = m_w.valid && m_wready && m_w.last;
  end

  // W-order FIFO storage
  always_ff @(posedge clk) begin
    if (aw_take_s) fifo_mem_r[fifo_wp_r] <= aw_idx_s;
  end

  // W-order FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_wp_r  <= {QW{1'b0}};
      fifo_rp_r  <= {QW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
    end else begin
      fifo_wp_r <= aw_take_s  ? fifo_wp_r + QW'(1) : fifo_wp_r;
      fifo_rp_r <= fifo_pop_s ? fifo_rp_r + QW'(1) : fifo_rp_r;
      case ({aw_take_s, fifo_pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // B/R routing by the index bits; unknown indices are sunk
  always_comb begin
    b_sel_s      = m_b.id[idw-1 -: ixw];
    r_sel_s      = m_r.id[idw-1 -: ixw];
    b_in_range_s = ({1'b0, b_sel_s} < NM_LIM);
    r_in_range_s = ({1'b0, r_sel_s} < NM_LIM);
    for (int i = 0; i < nm; i++) begin
      s_b[i]       = m_b;
      s_b[i].id    = strip_index(m_b.id, ixw);
      s_b[i].valid = rst && m_b.valid && b_in_range_s && (b_sel_s == ixw'(i));
      s_r[i]       = m_r;
      s_r[i].id    = strip_index(m_r.id, ixw);
      s_r[i].valid = rst && m_r.valid && r_in_range_s && (r_sel_s == ixw'(i));
    end
    if (!rst)              m_bready = 1'b0;
    else if (b_in_range_s) m_bready = s_bready[b_sel_s];
    else                   m_bready = 1'b1;
    if (!rst)              m_rready = 1'b0;
    else if (r_in_range_s) m_rready = s_rready[r_sel_s];
    else                   m_rready = 1'b1;
  end

endmodule

// File: tb/tb_axi_core_arbiter.sv
// Self-checking bench for axi_core_arbiter (nm=2, wqsz=4): directed scenarios plus
// randomized AR traffic and response routing against a behavioural model.
module tb_axi_core_arbiter;
  import axi_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  ar_t        s_ar [2];
  logic [1:0] s_arready;
  aw_t        s_aw [2];
  logic [1:0] s_awready;
  w_t         s_w [2];
  logic [1:0] s_wready;
  b_t         s_b [2];
  logic [1:0] s_bready;
  r_t         s_r [2];
  logic [1:0] s_rready;
  ar_t        m_ar;
  logic       m_arready;
  aw_t        m_aw;
  logic       m_awready;
  w_t         m_w;
  logic       m_wready;
  b_t         m_b;
  logic       m_bready;
  r_t         m_r;
  logic       m_rready;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  axi_core_arbiter #(.nm(2), .idw(8), .wqsz(4)) dut (
    .clk(clk), .rst(rst),
    .s_ar(s_ar), .s_arready(s_arready), .s_aw(s_aw), .s_awready(s_awready),
    .s_w(s_w), .s_wready(s_wready), .s_b(s_b), .s_bready(s_bready),
    .s_r(s_r), .s_rready(s_rready),
    .m_ar(m_ar), .m_arready(m_arready), .m_aw(m_aw), .m_awready(m_awready),
    .m_w(m_w), .m_wready(m_wready), .m_b(m_b), .m_bready(m_bready),
    .m_r(m_r), .m_rready(m_rready)
  );

  // Reference arbitration: best qos among valid masters (qos ignored without the feature), then first from ptr
  function automatic int pick(input logic [1:0] v, input logic [3:0] q0, input logic [3:0] q1, input int ptr);
    int qv [2];
    int maxq;
    qv[0] = q0;
    qv[1] = q1;
`ifndef AXI_ARB_QOS_EN
    qv[0] = 0;
    qv[1] = 0;
`endif
    maxq = -1;
    for (int i = 0; i < 2; i++) if (v[i] && qv[i] > maxq) maxq = qv[i];
    for (int k = 0; k < 2; k++) begin
      if (v[(ptr + k) % 2] && qv[(ptr + k) % 2] == maxq) return (ptr + k) % 2;
    end
    return -1;
  endfunction

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      s_ar[i] = '0;
      s_aw[i] = '0;
      s_w[i]  = '0;
    end
    s_bready = 2'b00; s_rready = 2'b00;
    m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_b = '0; m_r = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    s_ar[0].valid = 1'b1; s_aw[1].valid = 1'b1; s_w[0].valid = 1'b1;
    m_b.valid = 1'b1; m_b.id = 8'h80; m_r.valid = 1'b1; m_r.id = 8'h01;
    s_bready = 2'b11; s_rready = 2'b11;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({s_arready, s_awready, s_wready, m_bready, m_rready} !== 8'h00)
      $display("FAIL reset_readys: got %b want 0", {s_arready, s_awready, s_wready, m_bready, m_rready});
    else n_pass++;
    n_total++;
    if ({s_b[0].valid, s_b[1].valid, s_r[0].valid, s_r[1].valid} !== 4'b0000)
      $display("FAIL reset_resp_valid: got %b want 0000", {s_b[0].valid, s_b[1].valid, s_r[0].valid, s_r[1].valid});
    else n_pass++;
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    n_total++;
    if ({m_ar.valid, m_aw.valid, m_w.valid} !== 3'b000)
      $display("FAIL reset_m_valid: got %b want 000", {m_ar.valid, m_aw.valid, m_w.valid});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_rr_fairness();
    do_reset();
    s_ar[0].valid = 1'b1; s_ar[0].addr = 64'h1000; s_ar[0].id = 8'h00;
    s_ar[1].valid = 1'b1; s_ar[1].addr = 64'h2000; s_ar[1].id = 8'h00;
    m_arready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if ({m_ar.valid, m_ar.addr, m_ar.id} !== {1'b1, (k % 2 == 0) ? 64'h1000 : 64'h2000, (k % 2 == 0) ? 8'h00 : 8'h80})
        $display("FAIL rr_alternate[%0d]: got v=%b addr=%h id=%h", k, m_ar.valid, m_ar.addr, m_ar.id);
      else n_pass++;
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_ar_random();
    ar_t        exp_ar;
    int         ptr_m;
    int         w;
    logic       load;
    logic [1:0] exp_rdy;
    do_reset();
    exp_ar = '0;
    ptr_m = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        s_ar[i].valid = ($urandom_range(0, 3) != 0);
        s_ar[i].addr  = {$urandom, $urandom};
        s_ar[i].id    = 8'($urandom_range(0, 255));
        s_ar[i].len   = 8'($urandom_range(0, 255));
        s_ar[i].size  = 3'($urandom_range(0, 7));
        s_ar[i].burst = AXI_BURST_INCR;
        s_ar[i].cache = 4'($urandom_range(0, 15));
        s_ar[i].prot  = 3'($urandom_range(0, 7));
        s_ar[i].qos   = 4'($urandom_range(0, 15));
      end
      m_arready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_total++;
      if (exp_ar.valid ? (m_ar !== exp_ar) : (m_ar.valid !== 1'b0))
        $display("FAIL ar_payload[%0d]: got %h want %h", c, m_ar, exp_ar);
      else n_pass++;
      w = pick({s_ar[1].valid, s_ar[0].valid}, s_ar[0].qos, s_ar[1].qos, ptr_m);
      load = !exp_ar.valid || m_arready;
      exp_rdy = (load && w >= 0) ? (2'b01 << w) : 2'b00;
      n_total++;
      if (s_arready !== exp_rdy)
        $display("FAIL ar_ready[%0d]: got %b want %b", c, s_arready, exp_rdy);
      else n_pass++;
      if (load) begin
        if (w >= 0) begin
          exp_ar = s_ar[w];
          exp_ar.id = {w[0], s_ar[w].id[6:0]};
          ptr_m = (w + 1) % 2;
        end else begin
          exp_ar = '0;
        end
      end
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_w_ordering();
    do_reset();
    s_w[0].valid = 1'b1; s_w[0].data = 64'hA0; s_w[0].strb = 8'hFF; s_w[0].last = 1'b1;
    s_w[1].valid = 1'b1; s_w[1].data = 64'hB0; s_w[1].strb = 8'hFF; s_w[1].last = 1'b0;
    s_aw[1].valid = 1'b1; s_aw[1].len = 8'd3; s_aw[1].id = 8'h7A; s_aw[1].burst = AXI_BURST_INCR;
    m_awready = 1'b1; m_wready = 1'b1;
    @(negedge clk);
    n_total++;
    if ({m_w.valid, s_wready, s_awready} !== 5'b0_00_10)
      $display("FAIL w_before_aw: got wv=%b wr=%b awr=%b", m_w.valid, s_wready, s_awready);
    else n_pass++;
    @(posedge clk); #1;
    s_aw[1].valid = 1'b0;
    s_aw[0].valid = 1'b1; s_aw[0].len = 8'd0; s_aw[0].id = 8'hC3; s_aw[0].burst = AXI_BURST_INCR;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == 0) begin
        n_total++;
        if ({s_awready, m_aw.valid, m_aw.id, m_aw.len} !== {2'b01, 1'b1, 8'hFA, 8'd3})
          $display("FAIL aw_m1_tag: got awr=%b v=%b id=%h len=%0d", s_awready, m_aw.valid, m_aw.id, m_aw.len);
        else n_pass++;
      end
      if (b == 1) begin
        n_total++;
        if ({m_aw.valid, m_aw.id} !== {1'b1, 8'h43})
          $display("FAIL aw_m0_tag: got v=%b id=%h want 43", m_aw.valid, m_aw.id);
        else n_pass++;
      end
      n_total++;
      if ({m_w.valid, m_w.data, m_w.last, s_wready} !== {1'b1, 64'hB0 + 64'(b), (b == 3), 2'b10})
        $display("FAIL w_m1_beat[%0d]: got v=%b data=%h last=%b wr=%b", b, m_w.valid, m_w.data, m_w.last, s_wready);
      else n_pass++;
      @(posedge clk); #1;
      if (b == 0) s_aw[0].valid = 1'b0;
      if (b < 3) begin
        s_w[1].data = 64'hB0 + 64'(b + 1);
        s_w[1].last = (b + 1 == 3);
      end else begin
        s_w[1].valid = 1'b0;
      end
    end
    @(negedge clk);
    n_total++;
    if ({m_w.valid, m_w.data, m_w.last, s_wready} !== {1'b1, 64'hA0, 1'b1, 2'b01})
      $display("FAIL w_m0_beat: got v=%b data=%h last=%b wr=%b", m_w.valid, m_w.data, m_w.last, s_wready);
    else n_pass++;
    @(posedge clk); #1;
    s_w[0].valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (m_w.valid !== 1'b0) $display("FAIL w_drained: got v=%b want 0", m_w.valid);
    else n_pass++;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    s_aw[0].valid = 1'b1; s_aw[0].len = 8'd0;
    m_awready = 1'b1; m_wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_total++;
      if (s_awready !== 2'b01) $display("FAIL fifo_fill[%0d]: got awr=%b want 01", k, s_awready);
      else n_pass++;
      @(posedge clk); #1;
      s_aw[0].addr = 64'(k + 1);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_total++;
      if (s_awready !== 2'b00) $display("FAIL fifo_full_block[%0d]: got awr=%b want 00", k, s_awready);
      else n_pass++;
      @(posedge clk); #1;
    end
    s_w[0].valid = 1'b1; s_w[0].last = 1'b1; s_w[0].data = 64'h5;
    @(negedge clk);
    n_total++;
    if ({s_wready, s_awready} !== 4'b01_00) $display("FAIL fifo_pop_cycle: got wr=%b awr=%b", s_wready, s_awready);
    else n_pass++;
    @(posedge clk); #1;
    s_w[0].valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (s_awready !== 2'b01) $display("FAIL fifo_resume: got awr=%b want 01", s_awready);
    else n_pass++;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_resp_routing();
    logic [7:0]  id;
    logic        sel;
    int          nb, beat, cyc;
    logic [63:0] dat;
    logic [1:0]  exp_v;
    do_reset();
    for (int t = 0; t < 6; t++) begin
      id = (t == 0) ? 8'h85 : 8'($urandom_range(0, 255));
      sel = id[7];
      nb = (t == 0) ? 4 : $urandom_range(1, 4);
      exp_v = sel ? 2'b10 : 2'b01;
      beat = 0;
      dat = {$urandom, $urandom};
      for (cyc = 0; cyc < 64 && beat < nb; cyc++) begin
        @(posedge clk); #1;
        m_r.valid = 1'b1; m_r.id = id; m_r.data = dat; m_r.resp = AXI_RESP_OKAY; m_r.last = (beat == nb - 1);
        s_rready = (t == 0) ? ((cyc % 2 == 1) ? 2'b10 : 2'b00) : 2'($urandom_range(0, 3));
        @(negedge clk);
        n_total++;
        if ({s_r[1].valid, s_r[0].valid} !== exp_v || s_r[sel].id !== {1'b0, id[6:0]} || s_r[sel].data !== dat
            || s_r[sel].last !== (beat == nb - 1) || m_rready !== s_rready[sel])
          $display("FAIL r_route[%0d.%0d]: got v=%b id=%h last=%b rr=%b want v=%b id=%h last=%b rr=%b", t, beat,
                   {s_r[1].valid, s_r[0].valid}, s_r[sel].id, s_r[sel].last, m_rready,
                   exp_v, {1'b0, id[6:0]}, (beat == nb - 1), s_rready[sel]);
        else n_pass++;
        if (s_rready[sel]) begin
          beat++;
          dat = {$urandom, $urandom};
        end
      end
      n_total++;
      if (beat != nb) $display("FAIL r_timeout[%0d]: got %0d beats want %0d", t, beat, nb);
      else n_pass++;
      @(posedge clk); #1;
      m_r = '0; s_rready = 2'b00;
    end
    for (int t = 0; t < 4; t++) begin
      id = 8'($urandom_range(0, 255));
      sel = id[7];
      exp_v = sel ? 2'b10 : 2'b01;
      @(posedge clk); #1;
      m_b.valid = 1'b1; m_b.id = id; m_b.resp = 2'($urandom_range(0, 3));
      s_bready = 2'($urandom_range(0, 3));
      @(negedge clk);
      n_total++;
      if ({s_b[1].valid, s_b[0].valid} !== exp_v || s_b[sel].id !== {1'b0, id[6:0]} || s_b[sel].resp !== m_b.resp
          || m_bready !== s_bready[sel])
        $display("FAIL b_route[%0d]: got v=%b id=%h br=%b want v=%b id=%h br=%b", t,
                 {s_b[1].valid, s_b[0].valid}, s_b[sel].id, m_bready, exp_v, {1'b0, id[6:0]}, s_bready[sel]);
      else n_pass++;
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_mid_reset();
    do_reset();
    s_ar[0].valid = 1'b1; s_ar[0].addr = 64'h30;
    s_aw[1].valid = 1'b1; s_aw[1].len = 8'd3;
    s_w[1].valid = 1'b1; s_w[1].data = 64'hD0;
    m_awready = 1'b1; m_wready = 1'b1;
    @(posedge clk); #1;
    s_aw[1].valid = 1'b0; s_ar[0].valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_total++;
    if ({s_arready, s_awready, s_wready, m_bready, m_rready} !== 8'h00)
      $display("FAIL midrst_readys: got %b want 0", {s_arready, s_awready, s_wready, m_bready, m_rready});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    s_w[1].valid = 1'b1; s_w[1].data = 64'hD1;
    s_ar[0].valid = 1'b1; s_ar[1].valid = 1'b1;
    @(negedge clk);
    n_total++;
    if ({m_ar.valid, m_aw.valid, m_w.valid, s_wready} !== 5'b0)
      $display("FAIL midrst_state: got arv=%b awv=%b wv=%b wr=%b", m_ar.valid, m_aw.valid, m_w.valid, s_wready);
    else n_pass++;
    n_total++;
    if (s_arready !== 2'b01) $display("FAIL midrst_ptr: got arr=%b want 01", s_arready);
    else n_pass++;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_qos();
    logic [1:0] exp_rdy;
    do_reset();
    s_ar[0].valid = 1'b1; s_ar[0].qos = 4'd2; s_ar[0].addr = 64'h1000;
    s_ar[1].valid = 1'b1; s_ar[1].qos = 4'd9; s_ar[1].addr = 64'h2000;
    m_arready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        s_ar[0].qos = 4'd5;
        s_ar[1].qos = 4'd5;
      end
`ifdef AXI_ARB_QOS_EN
      exp_rdy = (k < 4) ? 2'b10 : ((k % 2 == 0) ? 2'b01 : 2'b10);
`else
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      @(negedge clk);
      n_total++;
      if (s_arready !== exp_rdy) $display("FAIL qos_grant[%0d]: got %b want %b", k, s_arready, exp_rdy);
      else n_pass++;
      @(posedge clk); #1;
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_rr_fairness();
    test_ar_random();
    test_w_ordering();
    test_fifo_full();
    test_resp_routing();
    test_mid_reset();
    test_qos();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
